// File: rtl/algo_rdtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : algo_rdtag_pkg
//  Description : Shared widths, saturation constant and helpers for the
//                read-tag tracking block.
//  Revision    : 1.0 - initial release
// ============================================================================
package algo_rdtag_pkg;

    localparam int unsigned c_cnt_w  = 16;
    localparam int unsigned c_port_w = 2;

    typedef logic [c_cnt_w-1:0]  cnt_t;
    typedef logic [c_port_w-1:0] port_idx_t;

    localparam cnt_t c_cnt_sat = 16'hFFFF;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic cnt_t sat_add(input cnt_t cnt, input cnt_t inc);
        logic [c_cnt_w:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[c_cnt_w] ? c_cnt_sat : sum[c_cnt_w-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/algo_rdtag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : algo_rdtag_fifo
//  Description : DEPTH x TAGW tag FIFO for one read port, exposing its
//                occupancy and a combinational view of the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module algo_rdtag_fifo #(
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4,
    parameter int BITDPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [TAGW-1:0]    push_tag,
    input  logic               pop,
    output logic [TAGW-1:0]    head_tag,
    output logic [BITDPTH:0]   occupancy
);

    localparam logic [BITDPTH:0]   c_full = (BITDPTH+1)'(DEPTH);
    localparam logic [BITDPTH-1:0] c_last = BITDPTH'(DEPTH-1);

    logic [TAGW-1:0]    r_mem [DEPTH];
    logic [BITDPTH-1:0] r_wptr;
    logic [BITDPTH-1:0] r_rptr;
    logic [BITDPTH:0]   r_occ;
    logic               w_push;
    logic               w_pop;

    // Guards make an overflow push or an underflow pop a no-op.
    assign w_push    = push && (r_occ != c_full);
    assign w_pop     = pop  && (r_occ != '0);
    assign head_tag  = r_mem[r_rptr];
    assign occupancy = r_occ;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/algo_4r6w1p_rdtag_track.sv
`default_nettype none
// ============================================================================
//  Module      : algo_4r6w1p_rdtag_track
//  Description : Per-port read tag tracking with in-order response tagging,
//                error statistics and orphan-response detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module algo_4r6w1p_rdtag_track
    import algo_rdtag_pkg::*;
#(
    parameter int NUMRDPT = 4,
    parameter int WIDTH   = 64,
    parameter int BITVBNK = 1,
    parameter int BITVROW = 13,
    parameter int BITPADR = 15,
    parameter int TAGW    = 4,
    parameter int DEPTH   = 4,
    parameter int BITDPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [NUMRDPT-1:0]           cl_read,
    input  logic [NUMRDPT*BITVBNK-1:0]   cl_badr,
    input  logic [NUMRDPT*BITVROW-1:0]   cl_radr,
    input  logic [NUMRDPT*TAGW-1:0]      cl_tag,
    output logic [NUMRDPT-1:0]           cl_rdy,

    input  logic                         ready,
    output logic [NUMRDPT-1:0]           read,
    output logic [NUMRDPT*BITVBNK-1:0]   rd_badr,
    output logic [NUMRDPT*BITVROW-1:0]   rd_radr,

    input  logic [NUMRDPT-1:0]           rd_vld,
    input  logic [NUMRDPT*WIDTH-1:0]     rd_dout,
    input  logic [NUMRDPT-1:0]           rd_serr,
    input  logic [NUMRDPT-1:0]           rd_derr,
    input  logic [NUMRDPT*BITPADR-1:0]   rd_padr,

    output logic [NUMRDPT-1:0]           rsp_vld,
    output logic [NUMRDPT*TAGW-1:0]      rsp_tag,
    output logic [NUMRDPT*WIDTH-1:0]     rsp_dout,
    output logic [NUMRDPT-1:0]           rsp_serr,
    output logic [NUMRDPT-1:0]           rsp_derr,

    input  logic                         clr_cnt,
    output logic [c_cnt_w-1:0]           serr_cnt,
    output logic [c_cnt_w-1:0]           derr_cnt,
    output logic [BITPADR-1:0]           derr_padr,
    output logic [c_port_w-1:0]          derr_port,
    output logic                         derr_seen,
    output logic [NUMRDPT-1:0]           orphan_err
);

    localparam int unsigned       c_inc_w = $clog2(NUMRDPT + 1);
    localparam logic [BITDPTH:0]  c_depth = (BITDPTH+1)'(DEPTH);

    logic [BITDPTH:0]         w_occ [NUMRDPT];
    logic [NUMRDPT*TAGW-1:0]  w_head;
    logic [NUMRDPT-1:0]       w_has_entry;

    logic [c_inc_w-1:0]       w_serr_inc;
    logic [c_inc_w-1:0]       w_derr_inc;
    logic                     w_derr_any;
    port_idx_t                w_derr_idx;
    logic [BITPADR-1:0]       w_derr_addr;

    assign rd_badr = cl_badr;
    assign rd_radr = cl_radr;

    generate
        for (genvar gi = 0; gi < NUMRDPT; gi++) begin : g_port
            // Acceptance looks only at the current occupancy; a pop in the
            // same cycle frees a slot for the following cycle.
            assign cl_rdy[gi]      = ready && !rst && (w_occ[gi] < c_depth);
            assign read[gi]        = cl_read[gi] && cl_rdy[gi];
            assign w_has_entry[gi] = (w_occ[gi] != '0);

            algo_rdtag_fifo #(
                .DEPTH   (DEPTH),
                .TAGW    (TAGW),
                .BITDPTH (BITDPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (read[gi]),
                .push_tag  (cl_tag[gi*TAGW +: TAGW]),
                .pop       (rd_vld[gi]),
                .head_tag  (w_head[gi*TAGW +: TAGW]),
                .occupancy (w_occ[gi])
            );
        end
    endgenerate

    // Response pipeline: payload fields only move when a response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld  <= '0;
            rsp_tag  <= '0;
            rsp_dout <= '0;
            rsp_serr <= '0;
            rsp_derr <= '0;
        end else begin
            for (int i = 0; i < NUMRDPT; i++) begin
                rsp_vld[i] <= rd_vld[i];
                if (rd_vld[i]) begin
                    rsp_tag[i*TAGW +: TAGW]    <= w_has_entry[i] ? w_head[i*TAGW +: TAGW] : '0;
                    rsp_dout[i*WIDTH +: WIDTH] <= rd_dout[i*WIDTH +: WIDTH];
                    rsp_serr[i]                <= rd_serr[i];
                    rsp_derr[i]                <= rd_derr[i];
                end
            end
        end
    end

    // Descending scan so the lowest-numbered erring port wins the capture.
    always_comb begin
        w_serr_inc  = '0;
        w_derr_inc  = '0;
        w_derr_any  = 1'b0;
        w_derr_idx  = '0;
        w_derr_addr = '0;
        for (int i = NUMRDPT - 1; i >= 0; i--) begin
            w_serr_inc = w_serr_inc + c_inc_w'(rd_vld[i] & rd_serr[i]);
            w_derr_inc = w_derr_inc + c_inc_w'(rd_vld[i] & rd_derr[i]);
            if (rd_vld[i] && rd_derr[i]) begin
                w_derr_any  = 1'b1;
                w_derr_idx  = c_port_w'(i);
                w_derr_addr = rd_padr[i*BITPADR +: BITPADR];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            serr_cnt   <= '0;
            derr_cnt   <= '0;
            derr_seen  <= 1'b0;
            derr_padr  <= '0;
            derr_port  <= '0;
            orphan_err <= '0;
        end else begin
            serr_cnt   <= sat_add(serr_cnt, cnt_t'(w_serr_inc));
            derr_cnt   <= sat_add(derr_cnt, cnt_t'(w_derr_inc));
            orphan_err <= orphan_err | (rd_vld & ~w_has_entry);
            if (!derr_seen && w_derr_any) begin
                derr_seen <= 1'b1;
                derr_padr <= w_derr_addr;
                derr_port <= w_derr_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_algo_4r6w1p_rdtag_track.sv
`default_nettype none
// ============================================================================
//  Module      : tb_algo_4r6w1p_rdtag_track
//  Description : Scoreboard bench for algo_4r6w1p_rdtag_track with a
//                queue-based reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_algo_4r6w1p_rdtag_track;

    localparam int NP = 4;
    localparam int W  = 64;
    localparam int BB = 1;
    localparam int BR = 13;
    localparam int BP = 15;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, ready, clr_cnt;
    logic [NP-1:0]     cl_read, cl_rdy, read;
    logic [NP*BB-1:0]  cl_badr, rd_badr;
    logic [NP*BR-1:0]  cl_radr, rd_radr;
    logic [NP*TW-1:0]  cl_tag, rsp_tag;
    logic [NP-1:0]     rd_vld, rd_serr, rd_derr;
    logic [NP*W-1:0]   rd_dout, rsp_dout;
    logic [NP*BP-1:0]  rd_padr;
    logic [NP-1:0]     rsp_vld, rsp_serr, rsp_derr, orphan_err;
    logic [15:0]       serr_cnt, derr_cnt;
    logic [BP-1:0]     derr_padr;
    logic [1:0]        derr_port;
    logic              derr_seen;

    algo_4r6w1p_rdtag_track dut (
        .clk(clk), .rst(rst),
        .cl_read(cl_read), .cl_badr(cl_badr), .cl_radr(cl_radr), .cl_tag(cl_tag),
        .cl_rdy(cl_rdy),
        .ready(ready), .read(read), .rd_badr(rd_badr), .rd_radr(rd_radr),
        .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr), .rd_derr(rd_derr),
        .rd_padr(rd_padr),
        .rsp_vld(rsp_vld), .rsp_tag(rsp_tag), .rsp_dout(rsp_dout),
        .rsp_serr(rsp_serr), .rsp_derr(rsp_derr),
        .clr_cnt(clr_cnt), .serr_cnt(serr_cnt), .derr_cnt(derr_cnt),
        .derr_padr(derr_padr), .derr_port(derr_port), .derr_seen(derr_seen),
        .orphan_err(orphan_err)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [W-1:0]  dout;
        logic          serr;
        logic          derr;
    } rsp_t;

    // Reference model: outstanding tags and expected responses per port.
    logic [TW-1:0] tq [NP][$];
    rsp_t          eq [NP][$];
    int            m_serr, m_derr;
    logic          m_seen;
    logic [BP-1:0] m_padr;
    logic [1:0]    m_port;
    logic [NP-1:0] m_orphan;
    logic [TW-1:0] last_tag  [NP];
    logic [W-1:0]  last_dout [NP];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; clr_cnt = 1'b0; cl_read = '0; cl_tag = '0;
        rd_vld = '0; rd_serr = '0; rd_derr = '0;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        logic [NP-1:0] exp_rdy, exp_read;
        rsp_t          r_e;
        int            ns, nd;
        bit            found;
        #1;
        for (int i = 0; i < NP; i++)
            exp_rdy[i] = ready && !rst && (tq[i].size() < 4);
        exp_read = exp_rdy & cl_read;
        chk("cl_rdy", cl_rdy, exp_rdy);
        chk("read", read, exp_read);
        chk("rd_badr", rd_badr, cl_badr);
        chk("rd_radr", rd_radr, cl_radr);

        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                tq[i].delete(); eq[i].delete();
                last_tag[i] = '0; last_dout[i] = '0;
            end
            m_serr = 0; m_derr = 0; m_seen = 1'b0;
            m_padr = '0; m_port = '0; m_orphan = '0;
        end else begin
            ns = 0; nd = 0; found = 1'b0;
            for (int i = 0; i < NP; i++) begin
                if (rd_vld[i]) begin
                    if (tq[i].size() != 0) r_e.tag = tq[i].pop_front();
                    else begin r_e.tag = '0; m_orphan[i] = 1'b1; end
                    r_e.dout = rd_dout[i*W +: W];
                    r_e.serr = rd_serr[i];
                    r_e.derr = rd_derr[i];
                    eq[i].push_back(r_e);
                    if (rd_serr[i]) ns++;
                    if (rd_derr[i]) nd++;
                end
                if (exp_read[i]) tq[i].push_back(cl_tag[i*TW +: TW]);
            end
            if (clr_cnt) begin
                m_serr = 0; m_derr = 0; m_seen = 1'b0;
                m_padr = '0; m_port = '0; m_orphan = '0;
            end else begin
                m_serr = (m_serr + ns > 65535) ? 65535 : m_serr + ns;
                m_derr = (m_derr + nd > 65535) ? 65535 : m_derr + nd;
                if (!m_seen) begin
                    for (int i = 0; i < NP; i++) begin
                        if (!found && rd_vld[i] && rd_derr[i]) begin
                            found = 1'b1;
                            m_padr = rd_padr[i*BP +: BP];
                            m_port = 2'(i);
                        end
                    end
                    if (found) m_seen = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compares registered outputs shortly after each rising edge.
    rsp_t r_m;
    always @(posedge clk) begin
        #3;
        if (mon_en) begin
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("rsp_vld[%0d]", i), rsp_vld[i], eq[i].size() != 0);
                if (eq[i].size() != 0) begin
                    r_m = eq[i].pop_front();
                    if (rsp_vld[i]) begin
                        chk($sformatf("rsp_tag[%0d]", i), rsp_tag[i*TW +: TW], r_m.tag);
                        chk($sformatf("rsp_dout[%0d]", i), rsp_dout[i*W +: W], r_m.dout);
                        chk($sformatf("rsp_serr[%0d]", i), rsp_serr[i], r_m.serr);
                        chk($sformatf("rsp_derr[%0d]", i), rsp_derr[i], r_m.derr);
                    end
                    last_tag[i]  = r_m.tag;
                    last_dout[i] = r_m.dout;
                end else if (!rsp_vld[i]) begin
                    chk($sformatf("hold_tag[%0d]", i), rsp_tag[i*TW +: TW], last_tag[i]);
                    chk($sformatf("hold_dout[%0d]", i), rsp_dout[i*W +: W], last_dout[i]);
                end
            end
            chk("serr_cnt", serr_cnt, m_serr[15:0]);
            chk("derr_cnt", derr_cnt, m_derr[15:0]);
            chk("derr_seen", derr_seen, m_seen);
            chk("derr_padr", derr_padr, m_padr);
            chk("derr_port", derr_port, m_port);
            chk("orphan_err", orphan_err, m_orphan);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        ready = 1'b1; cl_badr = '0; cl_radr = '0; rd_dout = '0; rd_padr = '0;
        mon_en = 1'b1;

        // Reset with requests pending: no acceptance during reset.
        rst = 1'b1; cl_read = 4'hF;
        repeat (2) begin
            cycle();
            chk("rdy_in_rst", cl_rdy, 4'h0);
        end

        // Memory not ready: nothing accepted.
        idle(); ready = 1'b0; cl_read = 4'hF; cl_tag = 16'hFFFF;
        repeat (2) begin
            cycle();
            chk("rdy_not_ready", cl_rdy, 4'h0);
        end
        ready = 1'b1;

        // Port 0: four tags fill the FIFO, the fifth is held off.
        idle();
        foreach (tq[0][k]) ; // no-op keeps ordering obvious
        cl_read = 4'b0001;
        cl_tag = 16'h0003; cycle();
        cl_tag = 16'h0007; cycle();
        cl_tag = 16'h0009; cycle();
        cl_tag = 16'h0002; cycle();
        cl_tag = 16'h0005; #1 chk("fifth_held", cl_rdy[0], 1'b0); cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            rd_vld = 4'b0001; rd_dout[63:0] = {$urandom, $urandom};
            cycle();
        end
        rd_vld = '0; cycle();

        // Port 2: simultaneous push and pop at occupancy 1.
        idle(); cl_read = 4'b0100; cl_tag = 16'h0A00; cycle();
        cl_tag = 16'h0600; rd_vld = 4'b0100; cycle();
        chk("p2_first_tag", rsp_tag[8 +: 4], 4'hA);
        cl_read = '0; cycle();
        chk("p2_second_tag", rsp_tag[8 +: 4], 4'h6);
        rd_vld = '0; cycle();

        // Multi-port error statistics and first double-error capture.
        idle(); clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
        rd_vld = 4'hF; rd_serr = 4'hF; rd_derr = 4'b0110;
        rd_padr = {15'h44, 15'h33, 15'h22, 15'h11};
        cycle();
        chk("serr_plus4", serr_cnt, 16'd4);
        chk("derr_plus2", derr_cnt, 16'd2);
        chk("derr_padr_22", derr_padr, 15'h22);
        chk("derr_port_1", derr_port, 2'd1);

        // Orphan on port 3, then reset with two tags outstanding on port 1.
        idle(); clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
        rd_vld = 4'b1000; cycle();
        chk("orphan3", orphan_err[3], 1'b1);
        chk("orphan3_tag", rsp_tag[12 +: 4], 4'h0);
        idle(); cl_read = 4'b0010; cl_tag = 16'h0050; cycle();
        cl_tag = 16'h0060; cycle();
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
        rd_vld = 4'b0010; cycle();
        chk("orphan_after_rst", orphan_err[1], 1'b1);
        chk("orphan_after_rst_tag", rsp_tag[4 +: 4], 4'h0);
        idle(); cycle();

        // Saturation: preload to 0xFFFE, then three single errors.
        idle(); clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
        rd_vld = 4'hF; rd_serr = 4'hF;
        repeat (16383) cycle();
        rd_vld = 4'h3; rd_serr = 4'h3; cycle();
        chk("serr_preload", serr_cnt, 16'hFFFE);
        rd_vld = 4'h1; rd_serr = 4'h1;
        repeat (3) cycle();
        chk("serr_saturated", serr_cnt, 16'hFFFF);
        clr_cnt = 1'b1; rd_derr = 4'h1; cycle();
        chk("serr_clr_priority", serr_cnt, 16'h0);
        chk("derr_clr_priority", derr_cnt, 16'h0);
        idle(); cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ready   = ($urandom_range(0, 9) != 0);
            rst     = ($urandom_range(0, 399) == 0);
            clr_cnt = ($urandom_range(0, 99) == 0);
            cl_read = 4'($urandom);
            cl_tag  = 16'($urandom);
            cl_badr = 4'($urandom);
            cl_radr = 52'({$urandom, $urandom});
            rd_serr = 4'($urandom);
            rd_derr = 4'($urandom & $urandom & $urandom);
            rd_padr = 60'({$urandom, $urandom});
            for (int i = 0; i < NP; i++) begin
                rd_vld[i] = (tq[i].size() != 0) ? ($urandom_range(0, 2) != 0)
                                                 : ($urandom_range(0, 19) == 0);
                rd_dout[i*W +: W] = {$urandom, $urandom};
            end
            cycle();
        end
        idle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
